// File: rtl/if_stage.sv
// Instruction-fetch stage: word-addressed PC, IF/ID pipeline register, decode redirects
// and a sticky out-of-range fetch fault that parks the stage in HALT until reset.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned IM_DEPTH = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] PC,
    input  logic [31:0] IM,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpTarget,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegAddr,
    output logic [31:0] IfId_Instr,
    output logic [31:0] IfId_PC1,
    output logic        IfId_Valid,
    output logic        Fault,
    output logic [31:0] FetchCount
);

    localparam logic [31:0] IM_LIMIT = 32'(IM_DEPTH);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e      state_q;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        pc_in_range;

    // Redirects only make sense against a valid instruction sitting in decode.
    always_comb begin
        redirect        = IfId_Valid & (JumpReg | Jump | BranchTaken);
        redirect_target = IfId_PC1 + {{16{BranchOffset[15]}}, BranchOffset};
        if (JumpReg) begin
            redirect_target = JumpRegAddr;
        end else if (Jump) begin
            redirect_target = {IfId_PC1[31:26], JumpTarget};
        end
        pc_in_range = (PC < IM_LIMIT);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StBoot;
            PC         <= RESET_PC;
            IfId_Instr <= 32'h0;
            IfId_PC1   <= 32'h0;
            IfId_Valid <= 1'b0;
            Fault      <= 1'b0;
            FetchCount <= 32'h0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    // One settle cycle for the memory load; nothing is fetched.
                    state_q <= StRun;
                end
                StRun: begin
                    if (!Stall) begin
                        if (redirect) begin
                            PC         <= redirect_target;
                            IfId_Valid <= 1'b0;
                        end else if (!pc_in_range) begin
                            Fault      <= 1'b1;
                            IfId_Valid <= 1'b0;
                            state_q    <= StHalt;
                        end else begin
                            IfId_Instr <= IM;
                            IfId_PC1   <= PC + 32'd1;
                            IfId_Valid <= 1'b1;
                            PC         <= PC + 32'd1;
                            FetchCount <= FetchCount + 32'd1;
                        end
                    end
                end
                StHalt: begin
                    IfId_Valid <= 1'b0;
                    Fault      <= 1'b1;
                end
                default: begin
                    state_q    <= StHalt;
                    IfId_Valid <= 1'b0;
                    Fault      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: instruction memory returns its own address (IM = PC).
module tb_if_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] PC;
    logic [31:0] IM;
    logic        Stall;
    logic        BranchTaken;
    logic [15:0] BranchOffset;
    logic        Jump;
    logic [25:0] JumpTarget;
    logic        JumpReg;
    logic [31:0] JumpRegAddr;
    logic [31:0] IfId_Instr;
    logic [31:0] IfId_PC1;
    logic        IfId_Valid;
    logic        Fault;
    logic [31:0] FetchCount;

    int n_vec;
    int n_miscmp;

    if_stage #(
        .RESET_PC (32'h0),
        .IM_DEPTH (64)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PC           (PC),
        .IM           (IM),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchOffset (BranchOffset),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .JumpReg      (JumpReg),
        .JumpRegAddr  (JumpRegAddr),
        .IfId_Instr   (IfId_Instr),
        .IfId_PC1     (IfId_PC1),
        .IfId_Valid   (IfId_Valid),
        .Fault        (Fault),
        .FetchCount   (FetchCount)
    );

    assign IM = PC;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_redirects();
        BranchTaken  = 1'b0;
        BranchOffset = 16'h0;
        Jump         = 1'b0;
        JumpTarget   = 26'h0;
        JumpReg      = 1'b0;
        JumpRegAddr  = 32'h0;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] fc);
        check({tag, "_pc"}, PC, pc);
        check({tag, "_instr"}, IfId_Instr, instr);
        check({tag, "_pc1"}, IfId_PC1, instr + 32'd1);
        check({tag, "_valid"}, {31'h0, IfId_Valid}, 32'd1);
        check({tag, "_fc"}, FetchCount, fc);
    endtask

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        Reset    = 1'b0;
        Stall    = 1'b0;
        clear_redirects();
        #2;
        check("rst_pc", PC, 32'h0);
        check("rst_instr", IfId_Instr, 32'h0);
        check("rst_pc1", IfId_PC1, 32'h0);
        check("rst_valid", {31'h0, IfId_Valid}, 32'd0);
        check("rst_fault", {31'h0, Fault}, 32'd0);
        check("rst_fc", FetchCount, 32'h0);
        step();
        step();
        Reset = 1'b1;

        // BOOT cycle: nothing fetched yet.
        step();
        check("boot_pc", PC, 32'h0);
        check("boot_valid", {31'h0, IfId_Valid}, 32'd0);
        check("boot_fc", FetchCount, 32'h0);

        for (int i = 0; i < 5; i++) begin
            step();
            check_fetch($sformatf("seq%0d", i), i + 1, i, i + 1);
        end

        // Stall at PC=5, with a redirect presented that must be ignored.
        Stall       = 1'b1;
        BranchTaken = 1'b1;
        BranchOffset = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            step();
            check_fetch($sformatf("stall%0d", i), 32'd5, 32'd4, 32'd5);
        end
        Stall = 1'b0;
        clear_redirects();
        step();
        check_fetch("resume", 32'd6, 32'd5, 32'd6);
        step();
        step();
        check_fetch("pre_br", 32'd8, 32'd7, 32'd8);

        // Backward branch from IfId_PC1=8 by -4.
        BranchTaken  = 1'b1;
        BranchOffset = 16'hFFFC;
        step();
        clear_redirects();
        check("br_pc", PC, 32'd4);
        check("br_valid", {31'h0, IfId_Valid}, 32'd0);
        check("br_pc1_hold", IfId_PC1, 32'd8);
        check("br_fc", FetchCount, 32'd8);
        step();
        check_fetch("br_tgt", 32'd5, 32'd4, 32'd9);

        // All three redirects at once: stalled first, then honoured with JumpReg priority.
        JumpReg      = 1'b1;
        JumpRegAddr  = 32'd20;
        Jump         = 1'b1;
        JumpTarget   = 26'd3;
        BranchTaken  = 1'b1;
        BranchOffset = 16'd2;
        Stall        = 1'b1;
        step();
        check_fetch("prio_stall", 32'd5, 32'd4, 32'd9);
        Stall = 1'b0;
        step();
        clear_redirects();
        check("prio_pc", PC, 32'd20);
        check("prio_valid", {31'h0, IfId_Valid}, 32'd0);
        step();
        check_fetch("prio_tgt", 32'd21, 32'd20, 32'd10);

        // Jump beats branch: {IfId_PC1[31:26], 3} = 3.
        Jump         = 1'b1;
        JumpTarget   = 26'd3;
        BranchTaken  = 1'b1;
        BranchOffset = 16'd9;
        step();
        clear_redirects();
        check("jmp_pc", PC, 32'd3);
        step();
        check_fetch("jmp_tgt", 32'd4, 32'd3, 32'd11);

        // Forward branch from IfId_PC1=4 by +2.
        BranchTaken  = 1'b1;
        BranchOffset = 16'd2;
        step();
        clear_redirects();
        check("brf_pc", PC, 32'd6);
        step();
        check_fetch("brf_tgt", 32'd7, 32'd6, 32'd12);

        // Run off the end of memory.
        JumpReg     = 1'b1;
        JumpRegAddr = 32'd62;
        step();
        clear_redirects();
        check("end_jr_pc", PC, 32'd62);
        step();
        check_fetch("end62", 32'd63, 32'd62, 32'd13);
        step();
        check_fetch("end63", 32'd64, 32'd63, 32'd14);
        check("end63_fault", {31'h0, Fault}, 32'd0);
        step();
        check("halt_fault", {31'h0, Fault}, 32'd1);
        check("halt_valid", {31'h0, IfId_Valid}, 32'd0);
        check("halt_pc", PC, 32'd64);
        for (int i = 0; i < 3; i++) step();
        check("halt_pc_frozen", PC, 32'd64);
        check("halt_fc_frozen", FetchCount, 32'd14);
        check("halt_instr_frozen", IfId_Instr, 32'd63);
        check("halt_fault_sticky", {31'h0, Fault}, 32'd1);

        // Leave HALT by reset, then reset again in the middle of a redirect.
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        step();
        check("reboot_pc", PC, 32'h0);
        check("reboot_fault", {31'h0, Fault}, 32'd0);
        step();
        check_fetch("rerun", 32'd1, 32'd0, 32'd1);
        JumpReg     = 1'b1;
        JumpRegAddr = 32'd40;
        #3;
        Reset = 1'b0;
        #1;
        check("midrst_pc", PC, 32'h0);
        check("midrst_valid", {31'h0, IfId_Valid}, 32'd0);
        check("midrst_pc1", IfId_PC1, 32'h0);
        check("midrst_fc", FetchCount, 32'h0);
        clear_redirects();
        step();
        Reset = 1'b1;
        step();
        check("midrst_boot_pc", PC, 32'h0);
        check("midrst_boot_valid", {31'h0, IfId_Valid}, 32'd0);
        step();
        check_fetch("midrst_run", 32'd1, 32'd0, 32'd1);

        // Out-of-range redirect target loads normally, faults on the next fetch.
        JumpReg     = 1'b1;
        JumpRegAddr = 32'd100;
        step();
        clear_redirects();
        check("oor_pc", PC, 32'd100);
        check("oor_fault_pre", {31'h0, Fault}, 32'd0);
        step();
        check("oor_fault", {31'h0, Fault}, 32'd1);
        check("oor_valid", {31'h0, IfId_Valid}, 32'd0);
        check("oor_pc_hold", PC, 32'd100);
        check("oor_fc", FetchCount, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0, the word address loaded into PC on reset.
REQ-002 SHALL provide parameter IM_DEPTH, default 64, the number of instruction words; legal PC range is 0..IM_DEPTH-1.
REQ-003 SHALL have Clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have Reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have PC  output  32  word address driven to instruction memory (word-indexed; +1 per instruction).
REQ-006 SHALL have IM  input  32  instruction word returned combinationally for PC.
REQ-007 SHALL have Stall  input  1  hold PC and IF/ID contents this cycle.
REQ-008 SHALL have BranchTaken  input  1, BranchOffset  input  16  conditional branch redirect from decode, offset signed, in words.
REQ-009 SHALL have Jump  input  1, JumpTarget  input  26  absolute jump redirect from decode.
REQ-010 SHALL have JumpReg  input  1, JumpRegAddr  input  32  register-indirect redirect from decode.
REQ-011 SHALL have IfId_Instr  output  32, IfId_PC1  output  32, IfId_Valid  output  1  IF/ID pipeline register (instruction, its PC+1, valid).
REQ-012 SHALL have Fault  output  1  sticky: fetch attempted outside 0..IM_DEPTH-1.
REQ-013 SHALL have FetchCount  output  32  number of valid instructions delivered into IF/ID since reset.

Function
REQ-014 SHALL implement states BOOT, RUN, HALT; BOOT entered on reset.
REQ-015 BOOT SHALL last exactly one Clk cycle after Reset deasserts (memory-load settle); PC held at RESET_PC, no IF/ID load, then -> RUN.
REQ-016 In RUN with Stall=0 and no redirect, each cycle SHALL load IfId_Instr<=IM, IfId_PC1<=PC+1, IfId_Valid<=1, PC<=PC+1, FetchCount<=FetchCount+1.
REQ-017 With Stall=1 (any state), PC, IfId_*, FetchCount SHALL hold; redirect inputs SHALL be ignored that cycle (decode re-presents them).
REQ-018 Redirects SHALL be honoured only when IfId_Valid=1 and Stall=0; priority JumpReg > Jump > BranchTaken.
REQ-019 Targets: JumpReg -> JumpRegAddr; Jump -> {IfId_PC1[31:26], JumpTarget}; Branch -> IfId_PC1 + sign-extended BranchOffset, 32-bit modulo arithmetic.
REQ-020 On an honoured redirect, PC<=target, IfId_Valid<=0 (wrong-path fetch squashed), IfId_Instr/IfId_PC1 hold, FetchCount unchanged; 1-cycle bubble.
REQ-021 If the PC value to be fetched in RUN is >= IM_DEPTH, the stage SHALL NOT load IF/ID, SHALL set Fault<=1, IfId_Valid<=0, -> HALT.
REQ-022 A redirect target >= IM_DEPTH SHALL be loaded into PC normally; the fault is raised on the following fetch cycle per REQ-021.
REQ-023 HALT SHALL be left only by Reset; PC, IfId_Instr, IfId_PC1, FetchCount frozen; IfId_Valid=0; Fault=1.
REQ-024 FetchCount SHALL wrap from 32'hFFFFFFFF to 0 without side effect.
REQ-025 PC output SHALL be a direct register output (no combinational path from any input to PC).

Reset
REQ-026 Reset low SHALL immediately force: state=BOOT, PC=RESET_PC, IfId_Instr=0, IfId_PC1=0, IfId_Valid=0, Fault=0, FetchCount=0.
REQ-027 Reset asserted mid-operation (any state, including during Stall or redirect) SHALL take effect without waiting for Clk; pending redirect is discarded.

Verification
REQ-028 Reset release, IM=PC pattern, no stall -> cycle 1 BOOT (Valid=0, PC=0); then PC 1,2,3; IfId_Instr 0,1,2; IfId_PC1 1,2,3; FetchCount 1,2,3.
REQ-029 Stall=1 for 3 cycles at PC=5 -> PC stays 5, IfId unchanged, FetchCount unchanged; resumes with PC=6 after release.
REQ-030 IfId_PC1=8, BranchTaken=1, BranchOffset=16'hFFFC -> PC=4 next cycle, IfId_Valid=0 one cycle, then instruction at 4 valid with IfId_PC1=5.
REQ-031 JumpReg=1 (JumpRegAddr=20), Jump=1 (JumpTarget=3), BranchTaken=1 same cycle -> PC=20 (priority check); with Stall=1 same inputs -> no redirect.
REQ-032 Run sequentially to PC=63 with IM_DEPTH=64 -> instruction 63 delivered, next cycle Fault=1, Valid=0, state HALT; PC frozen at 64 until Reset.
REQ-033 Assert Reset low mid-cycle during a redirect -> outputs reach reset values before next Clk edge; BOOT cycle repeats after release.
